// File: rtl/sfifo_pkg.sv
// ============================================================================
// sfifo_pkg : width helpers shared by the DMA FIFOs            rev 1.0
// ============================================================================
`default_nettype none

package sfifo_pkg;

  localparam int c_MIN_ADDR_W = 2;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  // The count needs one bit more than a pointer to represent "completely full".
  function automatic int cnt_width(input int addr_w);
    return addr_w + 1;
  endfunction

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sfifo_ptr.sv
// ============================================================================
// sfifo_ptr : binary wrap-around pointer with enable           rev 1.0
// ============================================================================
`default_nettype none

module sfifo_ptr
  import sfifo_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  output logic [WIDTH-1:0] ptr_o
);

  logic [WIDTH-1:0] ptr_q;
  logic [WIDTH-1:0] ptr_d;

  // Power-of-two depth: natural binary rollover is the wrap.
  always_comb begin
    ptr_d = ptr_q;
    if (en_i) begin
      ptr_d = ptr_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

`default_nettype wire

// File: rtl/sfifo.sv
// ============================================================================
// sfifo : single-clock FIFO, show-ahead or registered read     rev 1.0
// ============================================================================
`default_nettype none

module sfifo
  import sfifo_pkg::*;
#(
  parameter int DATA_WIDTH          = 8,
  parameter int ADDRESS_WIDTH       = 4,
  parameter int FIFO_DEPTH          = 1 << ADDRESS_WIDTH,
  parameter int FWFT                = 1,
  parameter int ALMOST_FULL_THRESH  = FIFO_DEPTH - 2,
  parameter int ALMOST_EMPTY_THRESH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  din,
  input  logic                   wr_en,
  output logic                   full,
  output logic                   almost_full,
  output logic                   overflow,
  output logic [DATA_WIDTH-1:0]  dout,
  input  logic                   rd_en,
  output logic                   empty,
  output logic                   almost_empty,
  output logic                   valid,
  output logic                   underflow,
  output logic [ADDRESS_WIDTH:0] count
);

  localparam int                c_CW    = cnt_width(ADDRESS_WIDTH);
  localparam logic [c_CW-1:0]   c_DEPTH = c_CW'(FIFO_DEPTH);
  localparam logic [c_CW-1:0]   c_AF    = c_CW'(ALMOST_FULL_THRESH);
  localparam logic [c_CW-1:0]   c_AE    = c_CW'(ALMOST_EMPTY_THRESH);

  logic [DATA_WIDTH-1:0]    mem_q [FIFO_DEPTH];
  logic [ADDRESS_WIDTH-1:0] w_wr_ptr;
  logic [ADDRESS_WIDTH-1:0] w_rd_ptr;
  logic                     w_wr_acc;
  logic                     w_rd_acc;
  logic [c_CW-1:0]          count_q;
  logic [c_CW-1:0]          count_d;
  logic                     full_q;
  logic                     empty_q;
  logic                     almost_full_q;
  logic                     almost_empty_q;
  logic                     overflow_q;
  logic                     underflow_q;

  assign w_wr_acc = wr_en & ~full_q  & ~rst;
  assign w_rd_acc = rd_en & ~empty_q & ~rst;
  assign count_d  = count_q + c_CW'(w_wr_acc) - c_CW'(w_rd_acc);

  sfifo_ptr #(.WIDTH(ADDRESS_WIDTH)) u_wr_ptr (
    .clk   (clk),
    .rst   (rst),
    .en_i  (w_wr_acc),
    .ptr_o (w_wr_ptr)
  );

  sfifo_ptr #(.WIDTH(ADDRESS_WIDTH)) u_rd_ptr (
    .clk   (clk),
    .rst   (rst),
    .en_i  (w_rd_acc),
    .ptr_o (w_rd_ptr)
  );

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      mem_q[w_wr_ptr] <= din;
    end
  end

  // A read that collides with a write into an empty FIFO is not flagged:
  // the requester sees the word next cycle, nothing is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q        <= '0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      almost_full_q  <= (c_AF == '0);
      almost_empty_q <= 1'b1;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      count_q        <= count_d;
      full_q         <= (count_d == c_DEPTH);
      empty_q        <= (count_d == '0);
      almost_full_q  <= (count_d >= c_AF);
      almost_empty_q <= (count_d <= c_AE);
      overflow_q     <= wr_en & full_q;
      underflow_q    <= rd_en & empty_q & ~wr_en;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign dout  = mem_q[w_rd_ptr];
      assign valid = ~empty_q;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] dout_q;
      logic                  valid_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          dout_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          valid_q <= w_rd_acc;
          if (w_rd_acc) begin
            dout_q <= mem_q[w_rd_ptr];
          end
        end
      end

      assign dout  = dout_q;
      assign valid = valid_q;
    end
  endgenerate

  assign count        = count_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

`default_nettype wire

// File: tb/tb_sfifo.sv
// ============================================================================
// tb_sfifo : queue-model bench for both sfifo read modes       rev 1.0
// ============================================================================
`default_nettype none

module tb_sfifo;

  localparam int c_DEPTH = 16;

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic       wr_en;
  logic       rd_en;

  logic       f_full, f_afull, f_ovf, f_empty, f_aempty, f_valid, f_udf;
  logic [7:0] f_dout;
  logic [4:0] f_count;
  logic       s_full, s_afull, s_ovf, s_empty, s_aempty, s_valid, s_udf;
  logic [7:0] s_dout;
  logic [4:0] s_count;

  int vectors;
  int miscompares;

  logic [7:0] q [$];
  logic       m_ovf;
  logic       m_udf;
  logic       m_svalid;
  logic [7:0] m_sdout;

  sfifo #(.FWFT(1)) dut_fwft (
    .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .full(f_full),
    .almost_full(f_afull), .overflow(f_ovf), .dout(f_dout), .rd_en(rd_en),
    .empty(f_empty), .almost_empty(f_aempty), .valid(f_valid),
    .underflow(f_udf), .count(f_count)
  );

  sfifo #(.FWFT(0)) dut_std (
    .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .full(s_full),
    .almost_full(s_afull), .overflow(s_ovf), .dout(s_dout), .rd_en(rd_en),
    .empty(s_empty), .almost_empty(s_aempty), .valid(s_valid),
    .underflow(s_udf), .count(s_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic w, input logic [7:0] d, input logic rd);
    int  n;
    logic is_full, is_empty;
    rst = r; wr_en = w; din = d; rd_en = rd;
    @(posedge clk);
    if (r) begin
      q.delete();
      m_ovf = 1'b0; m_udf = 1'b0; m_svalid = 1'b0; m_sdout = 8'h00;
    end else begin
      is_full  = (q.size() == c_DEPTH);
      is_empty = (q.size() == 0);
      m_ovf = w & is_full;
      m_udf = rd & is_empty & ~w;
      if (rd && !is_empty) begin
        m_sdout  = q.pop_front();
        m_svalid = 1'b1;
      end else begin
        m_svalid = 1'b0;
      end
      if (w && !is_full) q.push_back(d);
    end
    #1;
    n = q.size();
    check("count",        32'(f_count),  32'(n));
    check("std_count",    32'(s_count),  32'(n));
    check("full",         32'(f_full),   32'(n == c_DEPTH));
    check("std_full",     32'(s_full),   32'(n == c_DEPTH));
    check("empty",        32'(f_empty),  32'(n == 0));
    check("std_empty",    32'(s_empty),  32'(n == 0));
    check("almost_full",  32'(f_afull),  32'(n >= c_DEPTH - 2));
    check("almost_empty", 32'(f_aempty), 32'(n <= 2));
    check("std_afull",    32'(s_afull),  32'(n >= c_DEPTH - 2));
    check("std_aempty",   32'(s_aempty), 32'(n <= 2));
    check("overflow",     32'(f_ovf),    32'(m_ovf));
    check("underflow",    32'(f_udf),    32'(m_udf));
    check("std_overflow", 32'(s_ovf),    32'(m_ovf));
    check("std_underflow",32'(s_udf),    32'(m_udf));
    check("fwft_valid",   32'(f_valid),  32'(n != 0));
    if (n != 0) check("fwft_dout", 32'(f_dout), 32'(q[0]));
    check("std_valid",    32'(s_valid),  32'(m_svalid));
    check("std_dout",     32'(s_dout),   32'(m_sdout));
  endtask

  initial begin
    int w_pct;
    vectors = 0; miscompares = 0;
    m_ovf = 1'b0; m_udf = 1'b0; m_svalid = 1'b0; m_sdout = 8'h00;
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = 8'h00;

    step(1, 0, 8'h00, 0);
    step(1, 0, 8'h00, 0);
    step(0, 0, 8'h00, 0);
    step(0, 0, 8'h00, 0);

    // Fill with 0x00..0x0F, then one write too many.
    for (int i = 0; i < c_DEPTH; i++) step(0, 1, 8'(i), 0);
    step(0, 1, 8'hEE, 0);
    step(0, 0, 8'h00, 0);

    // Drain, then one read too many.
    for (int i = 0; i < c_DEPTH; i++) step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 0);

    step(0, 1, 8'hA5, 0);
    step(0, 1, 8'h5A, 0);
    step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 0);

    // Simultaneous read/write at full, then at empty.
    for (int i = 0; i < c_DEPTH; i++) step(0, 1, 8'($urandom), 0);
    step(0, 1, 8'h77, 1);
    while (q.size() != 0) step(0, 0, 8'h00, 1);
    step(0, 1, 8'h33, 1);

    // Stream at a steady count of 8 through several pointer wraps.
    while (q.size() < 8) step(0, 1, 8'($urandom), 0);
    for (int i = 0; i < 40; i++) step(0, 1, 8'($urandom), 1);

    // Reset mid-stream with a write pending.
    step(0, 1, 8'($urandom), 0);
    step(1, 1, 8'hCC, 0);
    step(0, 1, 8'h3C, 0);
    step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 0);

    // Random traffic with shifting write/read bias to reach both ends.
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) w_pct = int'($urandom_range(10, 90));
      step(($urandom_range(0, 99) == 0),
           (int'($urandom_range(0, 99)) < w_pct),
           8'($urandom),
           (int'($urandom_range(0, 99)) >= w_pct));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sfifo.md
# sfifo

Single-clock, parametrised FIFO for buffering data between blocks in one clock domain, e.g. DMA datapath staging ahead of the PCIe TX engine. It generalises the team's dual-port FIFO: a selectable show-ahead (FWFT) or standard read mode, an occupancy count, programmable almost-full/almost-empty thresholds, and overflow/underflow error pulses. Storage is an inferred dual-port RAM with no reset on the contents.

## Interface
- DATA_WIDTH, 8, word width in bits
- ADDRESS_WIDTH, 4, pointer width; ≥ 2
- FIFO_DEPTH, 1 << ADDRESS_WIDTH, number of entries; fixed at the power of two
- FWFT, 1, 1 = show-ahead read, 0 = standard registered read
- ALMOST_FULL_THRESH, FIFO_DEPTH-2, almost_full asserts at count ≥ this value
- ALMOST_EMPTY_THRESH, 2, almost_empty asserts at count ≤ this value

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- din  in  DATA_WIDTH  write data
- wr_en  in  1  write request
- full  out  1  no free entry
- almost_full  out  1  count ≥ ALMOST_FULL_THRESH
- overflow  out  1  one-cycle pulse: wr_en while full
- dout  out  DATA_WIDTH  read data
- rd_en  in  1  read request (pop)
- empty  out  1  no readable entry
- almost_empty  out  1  count ≤ ALMOST_EMPTY_THRESH
- valid  out  1  dout holds a popped word (FWFT=1: equals ~empty)
- underflow  out  1  one-cycle pulse: rd_en while empty
- count  out  ADDRESS_WIDTH+1  stored words, 0..FIFO_DEPTH

## Operation
- Accept rules use the registered flags at the start of the cycle: write accepted = wr_en & ~full; read accepted = rd_en & ~empty.
- Rejected requests leave pointers, count and memory unchanged and pulse overflow or underflow in the next cycle.
- Pointers are binary, ADDRESS_WIDTH bits, and wrap from FIFO_DEPTH-1 to 0.
- Count next = count + wr_acc − rd_acc. Full and empty come from count (full = count == FIFO_DEPTH), not from pointer compare.
- Both flags and both almost flags are registered from count next.
- Simultaneous accepted read and write: count unchanged and flags unchanged.
- When full, a simultaneous read and write accepts only the read. When empty, it accepts only the write; the write data does not pass through in the same cycle.
- FWFT=1: dout = mem[rd_ptr] (asynchronous read) and is valid whenever ~empty. rd_en pops the presented word.
- FWFT=0: on a read accept, dout <= mem[rd_ptr] and valid = 1 in the following cycle, otherwise valid = 0. dout holds its last value when no read occurs.
- Reset values: pointers 0, count 0, empty 1, almost_empty 1, full 0, almost_full 0 (1 if ALMOST_FULL_THRESH = 0), valid 0, dout 0 (FWFT=0 only), overflow 0, underflow 0.
- Reset mid-operation discards all contents; requests in the reset cycle are ignored and never pulse overflow or underflow.

## Timing
- Write to empty deassert: 1 cycle. A write at edge N makes empty = 0 after edge N.
- FWFT=1: the word is on dout in that same cycle.
- FWFT=0: rd_en → dout/valid latency is 1 cycle.
- Full after the FIFO_DEPTH-th accepted write with no reads: asserts 1 cycle after it.
- Back-to-back throughput: one write and one read per cycle sustained, with no bubbles at wrap-around.

## Structure
- Shared package sfifo_pkg holds the clog2 function and the count/pointer width localparam helpers used by other DMA FIFOs.
- One sub-module: sfifo_ptr, a binary wrap-around pointer with enable and synchronous reset, instantiated twice (write pointer, read pointer).
- Storage is an inferred memory array in the top module; the flag/count logic is in the top module.

## Test plan
- Reset, then idle → empty=1, almost_empty=1, full=0, count=0, valid=0, no error pulses.
- Defaults: write 16 words 0x00..0x0F with no reads.
  - Expected: almost_full rises at count=14, full after the 16th write, count=16.
  - A 17th write pulses overflow once, and count stays 16.
- FWFT=1: drain the full FIFO.
  - Expected: dout sequence 0x00..0x0F with no gaps.
  - almost_empty rises at count=2, empty after the last pop.
  - An extra rd_en pulses underflow.
- FWFT=0: write 0xA5, 0x5A, then rd_en for 2 cycles.
  - Expected: valid high 1 cycle after each rd_en, with dout = 0xA5 then 0x5A.
- Simultaneous rd_en and wr_en at full and at empty.
  - At full: count goes 16→15.
  - At empty: count goes 0→1, no underflow.
  - 40 cycles of streaming at count=8 keep count=8 across several pointer wraps, with data in order.
- Assert rst with count=9 mid-stream, wr_en=1.
  - Expected: next cycle count=0, empty=1, no overflow pulse.
  - A subsequent write/read returns the new data only.
